// File: rtl/answer_pkg.sv
// Shared types and constants for the quiz answer scheduler.
// Score saturation helpers keep the arithmetic identical wherever it is used.
package answer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StOpen   = 2'd1,
        StAnswer = 2'd2,
        StShow   = 2'd3
    } state_e;

    localparam int unsigned MAX_SCORE = 99;
    localparam int unsigned MIN_ID    = 1;
    localparam int unsigned MAX_ID    = 99;

    function automatic logic [7:0] sat_add(input logic [7:0] s, input int unsigned pts);
        if (32'(s) + pts > MAX_SCORE) begin
            return 8'(MAX_SCORE);
        end
        return s + 8'(pts);
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] s, input int unsigned pts);
        if (32'(s) < pts) begin
            return 8'd0;
        end
        return s - 8'(pts);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way combinational round-robin arbiter.
// The request vector is rotated so that bit 0 is the pointer position, then priority-encoded.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        off = 2'd0;
        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end else if (rot[2]) begin
            off = 2'd2;
        end else if (rot[3]) begin
            off = 2'd3;
        end
        gnt_valid = |req;
        gnt_idx   = ptr + off;
    end

endmodule

// File: rtl/answer_scheduler.sv
// Quiz-show buzzer scheduler: arbitrates buzzers, times answers, keeps per-player scores.
// All outputs come straight from flops.
module answer_scheduler
    import answer_pkg::*;
#(
    parameter int unsigned PTS_OK      = 2,
    parameter int unsigned PTS_BAD     = 1,
    parameter int unsigned ANS_TIMEOUT = 200,
    parameter int unsigned SHOW_CYCLES = 4
) (
    input  logic       clkout,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] buzz,
    input  logic       judge_ok,
    input  logic       judge_bad,
    output logic [1:0] player,
    output logic [7:0] score,
    output logic [7:0] problemID,
    output logic       show,
    output logic [1:0] state,
    output logic [3:0] lock
);

    localparam int unsigned TimerW = $clog2(ANS_TIMEOUT + 1);
    localparam int unsigned ShowW  = $clog2(SHOW_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ANS_TIMEOUT - 1);
    localparam logic [ShowW-1:0]  ShowLast  = ShowW'(SHOW_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        player_q, player_d;
    logic [7:0]        scores_q [4];
    logic [7:0]        scores_d [4];
    logic [7:0]        score_q, score_d;
    logic [7:0]        problem_id_q, problem_id_d;
    logic              show_q, show_d;
    logic [3:0]        lock_q, lock_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [ShowW-1:0]  show_cnt_q, show_cnt_d;

    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout, judge_good, judge_wrong;
    logic [3:0] lock_wrong;

    rr_arbiter4 u_arb (
        .req       (buzz & ~lock_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Conflicting judgements cancel; the timer alone can still force a wrong answer.
    assign timeout     = (timer_q == TimerLast);
    assign judge_good  = judge_ok & ~judge_bad;
    assign judge_wrong = (judge_bad & ~judge_ok) | (timeout & ~judge_good);
    assign lock_wrong  = lock_q | (4'b0001 << player_q);

    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StOpen;
            StOpen:   if (gnt_valid) state_d = StAnswer;
            StAnswer: begin
                if (judge_good) begin
                    state_d = StShow;
                end else if (judge_wrong) begin
                    state_d = (&lock_wrong) ? StShow : StOpen;
                end
            end
            StShow:   if (show_cnt_q == ShowLast) state_d = StIdle;
        endcase
    end

    always_comb begin
        player_d     = player_q;
        scores_d     = scores_q;
        problem_id_d = problem_id_q;
        lock_d       = lock_q;
        rr_ptr_d     = rr_ptr_q;
        timer_d      = timer_q;
        show_cnt_d   = show_cnt_q;
        unique case (state_q)
            StIdle: if (start) lock_d = 4'b0000;
            StOpen: begin
                if (gnt_valid) begin
                    player_d = gnt_idx;
                    rr_ptr_d = gnt_idx + 2'd1;
                    timer_d  = '0;
                end
            end
            StAnswer: begin
                timer_d = timer_q + 1'b1;
                if (judge_good) begin
                    scores_d[player_q] = sat_add(scores_q[player_q], PTS_OK);
                    show_cnt_d         = '0;
                end else if (judge_wrong) begin
                    scores_d[player_q] = sat_sub(scores_q[player_q], PTS_BAD);
                    lock_d             = lock_wrong;
                    show_cnt_d         = '0;
                end
            end
            StShow: begin
                show_cnt_d = show_cnt_q + 1'b1;
                if (show_cnt_q == ShowLast) begin
                    show_cnt_d   = '0;
                    problem_id_d = (problem_id_q == 8'(MAX_ID)) ? 8'(MIN_ID)
                                                                : problem_id_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        show_d  = (state_d == StShow);
        score_d = scores_d[player_d];
    end

    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            player_q     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                scores_q[i] <= 8'd0;
            end
            score_q      <= 8'd0;
            problem_id_q <= 8'(MIN_ID);
            show_q       <= 1'b0;
            lock_q       <= 4'b0000;
            rr_ptr_q     <= 2'd0;
            timer_q      <= '0;
            show_cnt_q   <= '0;
        end else begin
            player_q     <= player_d;
            scores_q     <= scores_d;
            score_q      <= score_d;
            problem_id_q <= problem_id_d;
            show_q       <= show_d;
            lock_q       <= lock_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            show_cnt_q   <= show_cnt_d;
        end
    end

    assign player    = player_q;
    assign score     = score_q;
    assign problemID = problem_id_q;
    assign show      = show_q;
    assign state     = state_q;
    assign lock      = lock_q;

endmodule

// File: tb/tb_answer_scheduler.sv
// Directed bench for answer_scheduler with hand-computed expectations.
module tb_answer_scheduler;

    logic       clkout = 1'b0;
    logic       rst_n;
    logic       start, judge_ok, judge_bad;
    logic [3:0] buzz;
    logic [1:0] player, state;
    logic [7:0] score, problemID;
    logic       show;
    logic [3:0] lock;

    int n_checks = 0;
    int n_errors = 0;

    answer_scheduler dut (
        .clkout    (clkout),
        .rst_n     (rst_n),
        .start     (start),
        .buzz      (buzz),
        .judge_ok  (judge_ok),
        .judge_bad (judge_bad),
        .player    (player),
        .score     (score),
        .problemID (problemID),
        .show      (show),
        .state     (state),
        .lock      (lock)
    );

    always #5 clkout = ~clkout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkout);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clkout);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_ok(input logic [3:0] b);
        start = 1'b1;
        step();
        start = 1'b0;
        buzz = b;
        step();
        buzz = 4'b0000;
        judge_ok = 1'b1;
        step();
        judge_ok = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        judge_ok = 1'b0;
        judge_bad = 1'b0;
        buzz = 4'b0000;
        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_player", 32'(player), 32'd0);
        check_eq("rst_pid", 32'(problemID), 32'd1);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_lock", 32'(lock), 32'd0);
        check_eq("rst_show", 32'(show), 32'd0);
        @(posedge clkout);
        #1;
        rst_n = 1'b1;

        // Round-robin from pointer 0 with everyone buzzing, each answer wrong.
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("rr_open", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            buzz = 4'b1111;
            step();
            buzz = 4'b0000;
            check_eq("rr_player", 32'(player), 32'(i));
            check_eq("rr_answer", 32'(state), 32'd2);
            if (i == 1) check_eq("rr_lock_p1", 32'(lock), 32'd1);
            judge_bad = 1'b1;
            step();
            judge_bad = 1'b0;
            check_eq("rr_lock", 32'(lock), (32'd1 << (i + 1)) - 32'd1);
            check_eq("rr_state", 32'(state), (i == 3) ? 32'd3 : 32'd1);
            check_eq("rr_score_floor", 32'(score), 32'd0);
        end
        repeat (3) step();
        check_eq("rr_show_last", 32'(show), 32'd1);
        step();
        check_eq("rr_idle", 32'(state), 32'd0);
        check_eq("rr_pid", 32'(problemID), 32'd2);

        // Single correct answer by player 2.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        buzz = 4'b0100;
        step();
        buzz = 4'b0000;
        check_eq("ok_player", 32'(player), 32'd2);
        check_eq("ok_answer", 32'(state), 32'd2);
        judge_ok = 1'b1;
        step();
        judge_ok = 1'b0;
        check_eq("ok_state", 32'(state), 32'd3);
        check_eq("ok_score", 32'(score), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check_eq("ok_show", 32'(show), 32'd1);
            step();
        end
        check_eq("ok_show_off", 32'(show), 32'd0);
        check_eq("ok_idle", 32'(state), 32'd0);
        check_eq("ok_pid", 32'(problemID), 32'd2);
        buzz = 4'b0100;
        step();
        buzz = 4'b0000;
        check_eq("idle_buzz", 32'(state), 32'd0);

        // Ignored judge in OPEN, cancelling judges, then timeout.
        start = 1'b1;
        step();
        start = 1'b0;
        judge_ok = 1'b1;
        step();
        judge_ok = 1'b0;
        check_eq("open_ignore", 32'(state), 32'd1);
        buzz = 4'b0100;
        step();
        buzz = 4'b0000;
        check_eq("to_player", 32'(player), 32'd2);
        check_eq("to_score0", 32'(score), 32'd2);
        judge_ok = 1'b1;
        judge_bad = 1'b1;
        step();
        judge_ok = 1'b0;
        judge_bad = 1'b0;
        check_eq("both_state", 32'(state), 32'd2);
        check_eq("both_score", 32'(score), 32'd2);
        repeat (198) step();
        check_eq("to_before", 32'(state), 32'd2);
        step();
        check_eq("to_state", 32'(state), 32'd1);
        check_eq("to_score", 32'(score), 32'd1);
        check_eq("to_lock", 32'(lock), 32'd4);
        buzz = 4'b0100;
        step();
        check_eq("locked_buzz", 32'(state), 32'd1);
        buzz = 4'b0001;
        step();
        buzz = 4'b0000;
        check_eq("p0_player", 32'(player), 32'd0);
        judge_ok = 1'b1;
        step();
        judge_ok = 1'b0;
        check_eq("p0_score", 32'(score), 32'd2);
        repeat (4) step();
        check_eq("p0_pid", 32'(problemID), 32'd3);

        // Score saturation and problem number wrap.
        do_reset();
        repeat (49) run_ok(4'b0001);
        check_eq("sat_98", 32'(score), 32'd98);
        check_eq("sat_pid50", 32'(problemID), 32'd50);
        run_ok(4'b0001);
        check_eq("sat_99", 32'(score), 32'd99);
        run_ok(4'b0001);
        check_eq("sat_hold", 32'(score), 32'd99);
        repeat (47) run_ok(4'b0001);
        check_eq("pid_99", 32'(problemID), 32'd99);
        run_ok(4'b0001);
        check_eq("pid_wrap", 32'(problemID), 32'd1);
        run_ok(4'b0001);
        check_eq("pid_2", 32'(problemID), 32'd2);

        // Asynchronous reset while in ANSWER.
        start = 1'b1;
        step();
        start = 1'b0;
        buzz = 4'b0010;
        step();
        buzz = 4'b0000;
        judge_bad = 1'b1;
        step();
        judge_bad = 1'b0;
        buzz = 4'b0001;
        step();
        buzz = 4'b0000;
        check_eq("ar_pre_state", 32'(state), 32'd2);
        check_eq("ar_pre_score", 32'(score), 32'd99);
        check_eq("ar_pre_lock", 32'(lock), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("ar_state", 32'(state), 32'd0);
        check_eq("ar_player", 32'(player), 32'd0);
        check_eq("ar_score", 32'(score), 32'd0);
        check_eq("ar_lock", 32'(lock), 32'd0);
        check_eq("ar_show", 32'(show), 32'd0);
        check_eq("ar_pid", 32'(problemID), 32'd1);
        step();
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
